// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: operand forwarding, immediate sign extension,
// load-use stall and valid/ready handshake. Optional counters under ID_EX_PERF_CNT_EN.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 15,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_op,
   input  logic [REG_W-1:0]  in_rs1_idx,
   input  logic [REG_W-1:0]  in_rs2_idx,
   input  logic [DATA_W-1:0] in_rs1_data,
   input  logic [DATA_W-1:0] in_rs2_data,
   input  logic [REG_W-1:0]  in_rd_idx,
   input  logic              in_wr_en,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic              in_use_imm,
   input  logic              ex_fwd_valid,
   input  logic [REG_W-1:0]  ex_fwd_rd,
   input  logic [DATA_W-1:0] ex_fwd_data,
   input  logic              mem_fwd_valid,
   input  logic [REG_W-1:0]  mem_fwd_rd,
   input  logic [DATA_W-1:0] mem_fwd_data,
   input  logic              ex_is_load,
   input  logic              flush,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [6:0]        out_op,
   output logic [DATA_W-1:0] out_x,
   output logic [DATA_W-1:0] out_y,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_wr_en
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   logic              hazard;
   logic              capture;
   logic [DATA_W-1:0] rs1_res;
   logic [DATA_W-1:0] rs2_res;
   logic [DATA_W-1:0] y_next;

   // A load in EX has no data yet, so a consumer of its rd must wait a cycle.
   always_comb begin
      hazard = 1'b0;
      if (ex_is_load && ex_fwd_valid && (ex_fwd_rd != '0)) begin
         if ((ex_fwd_rd == in_rs1_idx) || (!in_use_imm && (ex_fwd_rd == in_rs2_idx)))
            hazard = 1'b1;
      end
   end

   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign capture  = in_valid && in_ready && !flush;

   function automatic logic [DATA_W-1:0] resolve(input logic [REG_W-1:0]  idx,
                                                 input logic [DATA_W-1:0] rf_data);
      logic [DATA_W-1:0] val;
      val = rf_data;
      if (idx != '0) begin
         if (ex_fwd_valid && !ex_is_load && (ex_fwd_rd == idx))
            val = ex_fwd_data;
         else if (mem_fwd_valid && (mem_fwd_rd == idx))
            val = mem_fwd_data;
      end
      return val;
   endfunction

   always_comb begin
      rs1_res = resolve(in_rs1_idx, in_rs1_data);
      rs2_res = resolve(in_rs2_idx, in_rs2_data);
      if (in_use_imm)
         y_next = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
      else
         y_next = rs2_res;
   end

   // Data fields only load on capture; a drained slot keeps stale data.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_op    <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_rd    <= '0;
         out_wr_en <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_op    <= in_op;
         out_x     <= rs1_res;
         out_y     <= y_next;
         out_rd    <= in_rd_idx;
         out_wr_en <= in_wr_en;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (in_valid && !in_ready)
            stall_cnt <= stall_cnt + 32'd1;
         if (flush && (out_valid || in_valid))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed plan steps followed by random traffic against a
// transaction-level reference model. Counter checks compile in with ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;

   localparam logic [6:0] OP_ADD = 7'd0;
   localparam logic [6:0] OP_SUB = 7'd1;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_op;
   logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
   logic [31:0] in_rs1_data, in_rs2_data;
   logic        in_wr_en;
   logic [14:0] in_imm;
   logic        in_use_imm;
   logic        ex_fwd_valid, mem_fwd_valid;
   logic [4:0]  ex_fwd_rd, mem_fwd_rd;
   logic [31:0] ex_fwd_data, mem_fwd_data;
   logic        ex_is_load;
   logic        flush;
   logic        out_ready;
   logic        out_valid;
   logic [6:0]  out_op;
   logic [31:0] out_x, out_y;
   logic [4:0]  out_rd;
   logic        out_wr_en;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the instruction currently held by the stage, plus counters.
   typedef struct {
      logic        valid;
      logic [6:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [4:0]  rd;
      logic        wr;
   } slot_t;
   slot_t       m;
   logic [31:0] m_stall, m_flush;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_rd_idx(in_rd_idx), .in_wr_en(in_wr_en), .in_imm(in_imm), .in_use_imm(in_use_imm),
      .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
      .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
      .ex_is_load(ex_is_load), .flush(flush), .out_ready(out_ready),
      .out_valid(out_valid), .out_op(out_op), .out_x(out_x), .out_y(out_y),
      .out_rd(out_rd), .out_wr_en(out_wr_en)
`ifdef ID_EX_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_operand(input logic [4:0] idx, input logic [31:0] rf);
      if (idx == 5'd0) return rf;
      if (ex_fwd_valid && !ex_is_load && ex_fwd_rd == idx) return ex_fwd_data;
      if (mem_fwd_valid && mem_fwd_rd == idx) return mem_fwd_data;
      return rf;
   endfunction

   function automatic logic [31:0] model_imm(input logic [14:0] imm);
      int v;
      v = int'(imm);
      if (v >= 16384) v = v - 32768;
      return 32'(v);
   endfunction

   function automatic logic model_hazard();
      if (!(ex_is_load && ex_fwd_valid && ex_fwd_rd != 5'd0)) return 1'b0;
      return (ex_fwd_rd == in_rs1_idx) || (!in_use_imm && ex_fwd_rd == in_rs2_idx);
   endfunction

   // One clock: check in_ready ahead of the edge, advance the model, check outputs after.
   task automatic step(input string tag);
      logic  rdy, cap;
      slot_t nx;
      logic [31:0] nst, nfl;
      #1;
      rdy = (!m.valid || out_ready) && !model_hazard();
      if (in_valid) chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
      cap = in_valid && rdy && !flush;
      nx  = m;
      nst = m_stall;
      nfl = m_flush;
      if (reset) begin
         nx = '{1'b0, 7'd0, 32'd0, 32'd0, 5'd0, 1'b0};
         nst = 32'd0;
         nfl = 32'd0;
      end else begin
         if (in_valid && !rdy) nst = m_stall + 32'd1;
         if (flush && (m.valid || in_valid)) nfl = m_flush + 32'd1;
         if (flush) nx.valid = 1'b0;
         else if (cap) begin
            nx.valid = 1'b1;
            nx.op    = in_op;
            nx.x     = model_operand(in_rs1_idx, in_rs1_data);
            nx.y     = in_use_imm ? model_imm(in_imm) : model_operand(in_rs2_idx, in_rs2_data);
            nx.rd    = in_rd_idx;
            nx.wr    = in_wr_en;
         end else if (out_ready) nx.valid = 1'b0;
      end
      @(posedge clk);
      #1;
      m = nx;
      m_stall = nst;
      m_flush = nfl;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m.valid));
      if (m.valid || reset) begin
         chk({tag, ".out_op"}, 32'(out_op), 32'(m.op));
         chk({tag, ".out_x"}, out_x, m.x);
         chk({tag, ".out_y"}, out_y, m.y);
         chk({tag, ".out_rd"}, 32'(out_rd), 32'(m.rd));
         chk({tag, ".out_wr_en"}, 32'(out_wr_en), 32'(m.wr));
      end
`ifdef ID_EX_PERF_CNT_EN
      chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
      chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
`endif
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_op = OP_ADD; in_rs1_idx = 0; in_rs2_idx = 0; in_rd_idx = 0;
      in_rs1_data = 0; in_rs2_data = 0; in_wr_en = 0; in_imm = 0; in_use_imm = 0;
      ex_fwd_valid = 0; ex_fwd_rd = 0; ex_fwd_data = 0;
      mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
      ex_is_load = 0; flush = 0; out_ready = 1;
   endtask

   initial begin
      m = '{1'b0, 7'd0, 32'd0, 32'd0, 5'd0, 1'b0};
      m_stall = 0;
      m_flush = 0;
      idle_inputs();
      reset = 1;
      @(posedge clk); #1;
      step("reset");
      chk("reset.out_valid_zero", 32'(out_valid), 32'd0);
      chk("reset.out_x_zero", out_x, 32'd0);
      reset = 0;

      // Immediate path
      in_valid = 1; in_op = OP_ADD; in_use_imm = 1; in_imm = 15'b100000000000111;
      in_rs1_idx = 5'd1; in_rs1_data = 32'h00000001; in_rd_idx = 5'd2; in_wr_en = 1;
      step("imm");
      chk("imm.y_const", out_y, 32'hFFFFC007);
      chk("imm.x_const", out_x, 32'h00000001);

      // Forwarding priority
      in_use_imm = 0; in_rs1_idx = 5'd3; in_rs1_data = 32'h11111111;
      mem_fwd_valid = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h22222222;
      ex_fwd_valid = 1; ex_fwd_rd = 5'd3; ex_fwd_data = 32'h33333333;
      step("fwd_ex");
      chk("fwd_ex.x_const", out_x, 32'h33333333);
      ex_fwd_valid = 0;
      step("fwd_mem");
      chk("fwd_mem.x_const", out_x, 32'h22222222);
      ex_fwd_valid = 1; in_rs1_idx = 5'd0; ex_fwd_rd = 5'd0; mem_fwd_rd = 5'd0;
      step("fwd_zero");
      chk("fwd_zero.x_const", out_x, 32'h11111111);

      // Load-use hazard on rs2
      ex_is_load = 1; ex_fwd_valid = 1; ex_fwd_rd = 5'd5; in_rs2_idx = 5'd5;
      in_rs1_idx = 5'd1; in_use_imm = 0;
      step("ldu");
      chk("ldu.in_ready_low", 32'(in_ready), 32'd0);
      chk("ldu.drained", 32'(out_valid), 32'd0);
      in_use_imm = 1;
      #1;
      chk("ldu.imm_ready", 32'(in_ready), 32'd1);
      step("ldu_imm");
      ex_is_load = 0; ex_fwd_valid = 0; mem_fwd_valid = 0;

      // Back-pressure holding SUB 3, -1
      in_op = OP_SUB; in_use_imm = 0; in_rs1_idx = 5'd6; in_rs1_data = 32'h00000003;
      in_rs2_idx = 5'd7; in_rs2_data = 32'hFFFFFFFF; in_rd_idx = 5'd8;
      step("bp_load");
      out_ready = 0; in_op = OP_ADD; in_rs1_data = 32'hDEADBEEF; in_rs2_data = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         step("bp_hold");
         chk("bp_hold.x_const", out_x, 32'h00000003);
         chk("bp_hold.y_const", out_y, 32'hFFFFFFFF);
         chk("bp_hold.in_ready_low", 32'(in_ready), 32'd0);
      end
      out_ready = 1;
      step("bp_release");
      chk("bp_release.valid", 32'(out_valid), 32'd1);
      chk("bp_release.x_const", out_x, 32'hDEADBEEF);

      // Flush while stalled with a new instruction pending
      out_ready = 0; flush = 1;
      step("flush");
      chk("flush.valid_low", 32'(out_valid), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
      chk("flush.cnt_one", flush_cnt, 32'd1);
`endif
      flush = 0; out_ready = 1;

      // Reset mid-operation
      step("pre_rst_load");
      out_ready = 0;
      step("pre_rst_stall");
      reset = 1;
      step("mid_reset");
      chk("mid_reset.x_zero", out_x, 32'd0);
      chk("mid_reset.valid_zero", 32'(out_valid), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
      chk("mid_reset.stall_zero", stall_cnt, 32'd0);
`endif
      reset = 0;

      // Random traffic with narrow register indices to exercise matches
      for (int i = 0; i < 400; i++) begin
         reset         = ($urandom_range(0, 59) == 0);
         in_valid      = ($urandom_range(0, 9) < 8);
         in_op         = 7'($urandom);
         in_rs1_idx    = 5'($urandom_range(0, 3));
         in_rs2_idx    = 5'($urandom_range(0, 3));
         in_rd_idx     = 5'($urandom);
         in_rs1_data   = $urandom;
         in_rs2_data   = $urandom;
         in_wr_en      = 1'($urandom);
         in_imm        = 15'($urandom);
         in_use_imm    = ($urandom_range(0, 3) == 0);
         ex_fwd_valid  = 1'($urandom);
         ex_fwd_rd     = 5'($urandom_range(0, 3));
         ex_fwd_data   = $urandom;
         mem_fwd_valid = 1'($urandom);
         mem_fwd_rd    = 5'($urandom_range(0, 3));
         mem_fwd_data  = $urandom;
         ex_is_load    = ($urandom_range(0, 9) < 3);
         flush         = ($urandom_range(0, 9) == 0);
         out_ready     = ($urandom_range(0, 9) < 7);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
